// File: rtl/axi_burst_master.sv
// axi_burst_master: turns write/read commands plus payload streams into single-ID AXI4 INCR bursts of 4-byte beats
module axi_burst_master #(
  parameter int G_DATAWIDTH = 32,
  parameter int G_ID_WIDTH  = 1,
  parameter int G_ID        = 0,
  parameter int G_WEWIDTH   = ((G_DATAWIDTH - 1) / 8) + 1
) (
  input  logic                   s_aclk,
  input  logic                   s_areset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_write,
  input  logic [31:0]            cmd_addr,
  input  logic [7:0]             cmd_len,
  input  logic [G_DATAWIDTH-1:0] wr_data,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  output logic [G_DATAWIDTH-1:0] rd_data,
  output logic                   rd_valid,
  output logic                   rd_last,
  input  logic                   rd_ready,
  output logic                   done,
  output logic                   err,
  output logic [G_ID_WIDTH-1:0]  m_axi_awid,
  output logic [31:0]            m_axi_awaddr,
  output logic [7:0]             m_axi_awlen,
  output logic [2:0]             m_axi_awsize,
  output logic [1:0]             m_axi_awburst,
  output logic                   m_axi_awvalid,
  input  logic                   m_axi_awready,
  output logic [G_DATAWIDTH-1:0] m_axi_wdata,
  output logic [G_WEWIDTH-1:0]   m_axi_wstrb,
  output logic                   m_axi_wlast,
  output logic                   m_axi_wvalid,
  input  logic                   m_axi_wready,
  input  logic [G_ID_WIDTH-1:0]  m_axi_bid,
  input  logic [1:0]             m_axi_bresp,
  input  logic                   m_axi_bvalid,
  output logic                   m_axi_bready,
  output logic [G_ID_WIDTH-1:0]  m_axi_arid,
  output logic [31:0]            m_axi_araddr,
  output logic [7:0]             m_axi_arlen,
  output logic [2:0]             m_axi_arsize,
  output logic [1:0]             m_axi_arburst,
  output logic                   m_axi_arvalid,
  input  logic                   m_axi_arready,
  input  logic [G_ID_WIDTH-1:0]  m_axi_rid,
  input  logic [G_DATAWIDTH-1:0] m_axi_rdata,
  input  logic [1:0]             m_axi_rresp,
  input  logic                   m_axi_rlast,
  input  logic                   m_axi_rvalid,
  output logic                   m_axi_rready
);
  typedef enum logic [2:0] {IDLE, WADDR, WDATA, WRESP, RADDR, RDATA, DONE} state_t;
  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [7:0]  len_q, len_d, cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        at_last, w_hs, r_hs, unused_ok;
  assign at_last   = cnt_q == len_q;
  assign unused_ok = ^{m_axi_bid, m_axi_rid};
  assign cmd_ready     = state_q == IDLE;
  assign m_axi_awid    = G_ID_WIDTH'(G_ID);
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awlen   = len_q;
  assign m_axi_awsize  = 3'b010;
  assign m_axi_awburst = 2'b01;
  assign m_axi_awvalid = state_q == WADDR;
  assign m_axi_wvalid  = (state_q == WDATA) & wr_valid;
  assign wr_ready      = (state_q == WDATA) & m_axi_wready;
  assign m_axi_wdata   = state_q == WDATA ? wr_data : '0;
  assign m_axi_wstrb   = '1;
  assign m_axi_wlast   = (state_q == WDATA) & at_last;
  assign m_axi_bready  = state_q == WRESP;
  assign m_axi_arid    = G_ID_WIDTH'(G_ID);
  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = len_q;
  assign m_axi_arsize  = 3'b010;
  assign m_axi_arburst = 2'b01;
  assign m_axi_arvalid = state_q == RADDR;
  assign rd_valid      = (state_q == RDATA) & m_axi_rvalid;
  assign m_axi_rready  = (state_q == RDATA) & rd_ready;
  assign rd_data       = state_q == RDATA ? m_axi_rdata : '0;
  assign rd_last       = (state_q == RDATA) & m_axi_rlast;
  assign done          = state_q == DONE;
  assign err           = (state_q == DONE) & err_q;
  assign w_hs = m_axi_wvalid & wr_ready;
  assign r_hs = rd_valid & m_axi_rready;
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (cmd_valid) begin
        addr_d  = cmd_addr;
        len_d   = cmd_len;
        cnt_d   = '0;
        err_d   = 1'b0;
        state_d = cmd_write ? WADDR : RADDR;
      end
      WADDR: state_d = m_axi_awready ? WDATA : WADDR;
      WDATA: if (w_hs) begin
        cnt_d   = cnt_q + 8'd1;
        state_d = at_last ? WRESP : WDATA;
      end
      WRESP: if (m_axi_bvalid) begin
        err_d   = err_q | (m_axi_bresp != 2'b00);
        state_d = DONE;
      end
      RADDR: state_d = m_axi_arready ? RDATA : RADDR;
      // An early or missing RLAST still ends the burst, but flags the mismatch
      RDATA: if (r_hs) begin
        cnt_d   = cnt_q + 8'd1;
        err_d   = err_q | (m_axi_rresp != 2'b00) | (m_axi_rlast != at_last);
        state_d = (m_axi_rlast | at_last) ? DONE : RDATA;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge s_aclk) begin
    if (s_areset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: doc/axi_burst_master.md
Name: axi_burst_master

Overview:
- AXI4 initiator that drives the s_axi_* slave port of the team's AXI block-memory slave, or any AXI4 slave with the same profile: INCR bursts, 4-byte beats, single ID.
- Converts a simple command interface (write/read, address, length) plus valid/ready data streams into complete AXI4 write or read bursts.
- Reports completion and response status per command.
- Used as the test/DMA front end for memory-mapped block RAMs.

Parameters:
- G_DATAWIDTH, 32, AXI data width in bits; this revision supports 32 only.
- G_ID_WIDTH, 1, width of AWID/ARID/BID/RID.
- G_ID, 0, constant ID driven on AWID/ARID.
- G_WEWIDTH, ((G_DATAWIDTH-1)/8)+1, WSTRB width.

Ports:
- s_aclk  in  1  clock; all logic on rising edge.
- s_areset  in  1  synchronous reset, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block idle, command accepted on cmd_valid&cmd_ready.
- cmd_write  in  1  1 = write burst, 0 = read burst.
- cmd_addr  in  32  byte start address, 4-byte aligned.
- cmd_len  in  8  beats minus 1 (AXI LEN encoding).
- wr_data  in  G_DATAWIDTH  write payload stream.
- wr_valid  in  1  payload beat valid.
- wr_ready  out  1  payload beat consumed.
- rd_data  out  G_DATAWIDTH  read payload stream.
- rd_valid  out  1  read beat valid.
- rd_last  out  1  final beat of the burst.
- rd_ready  in  1  downstream accepts read beat.
- done  out  1  one-cycle pulse at command completion.
- err  out  1  valid with done; 1 = non-OKAY response or RLAST mismatch.
- m_axi_aw*  out  awid G_ID_WIDTH, awaddr 32, awlen 8, awsize 3, awburst 2, awvalid 1; awready in 1.
- m_axi_w*  out  wdata G_DATAWIDTH, wstrb G_WEWIDTH, wlast 1, wvalid 1; wready in 1.
- m_axi_b*  in  bid G_ID_WIDTH, bresp 2, bvalid 1; bready out 1.
- m_axi_ar*  out  arid, araddr 32, arlen 8, arsize 3, arburst 2, arvalid 1; arready in 1.
- m_axi_r*  in  rid, rdata, rresp 2, rlast 1, rvalid 1; rready out 1.

Behaviour:
- Reset (s_areset=1 at an edge): state IDLE, beat counter 0, err latch 0. All valid/ready outputs are 0 at the next edge, except cmd_ready=1. done=0, addr/len/data outputs=0.
- Reset mid-burst: the transaction is abandoned with no done pulse; the slave must be reset together with this block.
- Constants:
  - awsize=arsize=3'b010.
  - awburst=arburst=2'b01 (INCR).
  - wstrb all ones.
  - awid=arid=G_ID.
- States: IDLE, WADDR, WDATA, WRESP, RADDR, RDATA, DONE.
- IDLE: cmd_ready=1. On cmd_valid, register addr and len, clear counter and err.
  - cmd_write=1: go to WADDR.
  - cmd_write=0: go to RADDR.
- WADDR: awvalid=1 (registered, first driven the cycle after acceptance), held stable until awready. On handshake go to WDATA.
- W data is never issued before the AW handshake.
- WDATA:
  - Combinational pass-through: m_axi_wvalid=wr_valid, wr_ready=m_axi_wready, wdata=wr_data.
  - wlast=(counter==len).
  - Each wvalid&wready increments the counter.
  - Handshake with wlast: go to WRESP.
  - len=0 gives a single beat with wlast=1.
  - Throughput: 1 beat/cycle.
- WRESP: bready=1. On bvalid, err|=(bresp!=0), go to DONE.
- RADDR: arvalid=1, araddr/arlen from registers; held until arready. Go to RDATA.
- RDATA:
  - Combinational pass-through: rd_valid=m_axi_rvalid, m_axi_rready=rd_ready, rd_data=rdata, rd_last=rlast.
  - Each handshake increments the counter; err|=(rresp!=0).
  - Handshake with rlast=1, or with counter==len: go to DONE. err|=(rlast != (counter==len)).
  - rd_ready low stalls with no beat loss.
- DONE: done=1 and err valid for exactly one cycle; cmd_ready=0; return to IDLE.
- Minimum command-to-command spacing is 1 idle cycle, so back-to-back commands are accepted every burst+3 cycles or more.
- Counter is 8-bit and never wraps: len=255 gives 256 beats, and last asserts at 255.
- Address is not incremented by this block (the slave does INCR). 4 KB boundary crossing is the caller's responsibility and is not checked.
- bid/rid are ignored (single outstanding transaction).

Test Plan:
- Reset held 3 cycles, then released -> cmd_ready=1, awvalid=arvalid=wvalid=bready=rready=0, done=0.
- Write addr 0x10, len 3, data 0xA0..0xA3, slave always ready -> one AW (awlen=3, awsize=2, awburst=1), 4 W beats with wlast on the 4th only, done=1 err=0 one cycle after B.
- Read addr 0x10, len 3 -> arlen=3; rd_data 0xA0..0xA3 with rd_last on 4th; rd_ready toggled 1,0,1,0 -> no beat lost or duplicated, done err=0.
- Single-beat write then read (len 0) at 0x3FC, data 0xDEADBEEF -> wlast on the only beat; readback 0xDEADBEEF with rd_last=1.
- Slave model returns bresp=2'b10, then a read with rlast asserted on beat 2 of a len=3 read -> done with err=1 for both.
- Assert s_areset in WDATA after 2 beats -> next edge all AXI valids low, cmd_ready=1, no done pulse; a new len=1 write then completes normally.
